// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//   Sequencing stage in front of the combinational 4-bit divider. Takes one
//   divide op from decode, drives registered operands into the divider, waits
//   SETTLE_CYCLES edges for the divider outputs to settle, captures the result
//   with its writeback tag and holds it for writeback until consumed.
//   Divide-by-zero is detected from the divisor and produces quo=all-ones,
//   rem=dividend regardless of what the divider reports.
//
// Parameters
//   WIDTH          operand/result width (must match the divider)
//   SETTLE_CYCLES  divider settle time in cycles, must be >= 1
//   DEST_W         writeback register-address width
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          decode handshake (in_ready is combinational)
//   in_a, in_b, in_dest        dividend, divisor, destination tag
//   div_a, div_b               registered operands to the divider
//   div_quo, div_rem           divider quotient / remainder
//   out_valid/out_ready        writeback handshake
//   out_quo, out_rem           captured quotient / remainder
//   out_dest, out_dbz          captured tag, divide-by-zero flag
//   op_count                   completed ops, wraps at 256
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned DEST_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [DEST_W-1:0] in_dest,
  output logic [WIDTH-1:0]  div_a,
  output logic [WIDTH-1:0]  div_b,
  input  logic [WIDTH-1:0]  div_quo,
  input  logic [WIDTH-1:0]  div_rem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_quo,
  output logic [WIDTH-1:0]  out_rem,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_dbz,
  output logic [7:0]        op_count
);

  // Counter only needs to hold SETTLE_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned OPC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // State and registered outputs
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_div_a;
  logic [WIDTH-1:0]    r_div_b;
  logic [DEST_W-1:0]   r_dest_h;
  logic                r_dbz_h;
  logic [WIDTH-1:0]    r_out_quo;
  logic [WIDTH-1:0]    r_out_rem;
  logic [DEST_W-1:0]   r_out_dest;
  logic                r_out_dbz;
  logic                r_out_valid;
  logic [OPC_W-1:0]    r_op_count;

  // Next-state values
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0]    w_div_a_nxt;
  logic [WIDTH-1:0]    w_div_b_nxt;
  logic [DEST_W-1:0]   w_dest_h_nxt;
  logic                w_dbz_h_nxt;
  logic [WIDTH-1:0]    w_out_quo_nxt;
  logic [WIDTH-1:0]    w_out_rem_nxt;
  logic [DEST_W-1:0]   w_out_dest_nxt;
  logic                w_out_dbz_nxt;
  logic                w_out_valid_nxt;
  logic [OPC_W-1:0]    w_op_count_nxt;

  // Ready is held low during reset so decode cannot hand off an op that is lost.
  assign in_ready = (r_state == ST_IDLE) && rst_n;

  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign out_valid = r_out_valid;
  assign out_quo   = r_out_quo;
  assign out_rem   = r_out_rem;
  assign out_dest  = r_out_dest;
  assign out_dbz   = r_out_dbz;
  assign op_count  = r_op_count;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_dest_h    <= '0;
      r_dbz_h     <= 1'b0;
      r_out_quo   <= '0;
      r_out_rem   <= '0;
      r_out_dest  <= '0;
      r_out_dbz   <= 1'b0;
      r_out_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div_a     <= w_div_a_nxt;
      r_div_b     <= w_div_b_nxt;
      r_dest_h    <= w_dest_h_nxt;
      r_dbz_h     <= w_dbz_h_nxt;
      r_out_quo   <= w_out_quo_nxt;
      r_out_rem   <= w_out_rem_nxt;
      r_out_dest  <= w_out_dest_nxt;
      r_out_dbz   <= w_out_dbz_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_op_count  <= w_op_count_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_div_a_nxt     = r_div_a;
    w_div_b_nxt     = r_div_b;
    w_dest_h_nxt    = r_dest_h;
    w_dbz_h_nxt     = r_dbz_h;
    w_out_quo_nxt   = r_out_quo;
    w_out_rem_nxt   = r_out_rem;
    w_out_dest_nxt  = r_out_dest;
    w_out_dbz_nxt   = r_out_dbz;
    w_out_valid_nxt = r_out_valid;
    w_op_count_nxt  = r_op_count;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_div_a_nxt  = in_a;
          w_div_b_nxt  = in_b;
          w_dest_h_nxt = in_dest;
          w_dbz_h_nxt  = (in_b == '0);
          w_cnt_nxt    = CNT_W'(SETTLE_CYCLES - 1);
          w_state_nxt  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          // Divider output is meaningless for a zero divisor; substitute the
          // architectural result instead.
          if (r_dbz_h) begin
            w_out_quo_nxt = {WIDTH{1'b1}};
            w_out_rem_nxt = r_div_a;
          end else begin
            w_out_quo_nxt = div_quo;
            w_out_rem_nxt = div_rem;
          end
          w_out_dest_nxt  = r_dest_h;
          w_out_dbz_nxt   = r_dbz_h;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_op_count_nxt  = r_op_count + OPC_W'(1);
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_issue_ctrl
//   Two instances: index 0 with SETTLE_CYCLES=1, index 1 with SETTLE_CYCLES=3.
//   A behavioural divider drives div_quo/div_rem (random junk for divisor 0).
//   Expected results come from plain arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_div_issue_ctrl;

  logic       clk;
  logic       rst_n     [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [3:0] in_a      [2];
  logic [3:0] in_b      [2];
  logic [2:0] in_dest   [2];
  logic [3:0] div_a     [2];
  logic [3:0] div_b     [2];
  logic [3:0] div_quo   [2];
  logic [3:0] div_rem   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [3:0] out_quo   [2];
  logic [3:0] out_rem   [2];
  logic [2:0] out_dest  [2];
  logic       out_dbz   [2];
  logic [7:0] op_count  [2];

  logic [3:0] junk;
  int n_checks;
  int n_fail;
  int exp_cnt [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1), .DEST_W(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_dest(in_dest[0]),
    .div_a(div_a[0]), .div_b(div_b[0]), .div_quo(div_quo[0]), .div_rem(div_rem[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_quo(out_quo[0]),
    .out_rem(out_rem[0]), .out_dest(out_dest[0]), .out_dbz(out_dbz[0]),
    .op_count(op_count[0])
  );

  div_issue_ctrl #(.WIDTH(4), .SETTLE_CYCLES(3), .DEST_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_dest(in_dest[1]),
    .div_a(div_a[1]), .div_b(div_b[1]), .div_quo(div_quo[1]), .div_rem(div_rem[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_quo(out_quo[1]),
    .out_rem(out_rem[1]), .out_dest(out_dest[1]), .out_dbz(out_dbz[1]),
    .op_count(op_count[1])
  );

  // Behavioural stand-in for divider_4bit
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      if (div_b[g] == 4'd0) begin
        div_quo[g] = junk;
        div_rem[g] = ~junk;
      end else begin
        div_quo[g] = div_a[g] / div_b[g];
        div_rem[g] = div_a[g] % div_b[g];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic int settle_of(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    junk = 4'($urandom);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One full op: accept, latency, optional stall (with an ignored intruder op), handshake.
  task automatic do_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] d, input int hold, input bit intrude);
    logic [3:0] eq;
    logic [3:0] er;
    logic       edbz;
    int         w;
    edbz = (b == 4'd0);
    eq   = edbz ? 4'hF : 4'(a / b);
    er   = edbz ? a : 4'(a % b);

    w = 0;
    while (!in_ready[idx] && w < 50) begin step(); w++; end
    chk("accept_ready", 32'(in_ready[idx]), 32'd1);

    in_valid[idx] = 1'b1;
    in_a[idx]     = a;
    in_b[idx]     = b;
    in_dest[idx]  = d;
    step();
    in_valid[idx]  = 1'b0;
    in_a[idx]      = 4'($urandom);
    in_b[idx]      = 4'($urandom);
    in_dest[idx]   = 3'($urandom);
    // out_ready while nothing is valid must have no effect
    out_ready[idx] = 1'($urandom);
    chk("div_a", 32'(div_a[idx]), 32'(a));
    chk("div_b", 32'(div_b[idx]), 32'(b));

    w = 1;
    while (!out_valid[idx] && w < 50) begin
      chk("early_opcnt", 32'(op_count[idx]), 32'(exp_cnt[idx]));
      step();
      w++;
    end
    out_ready[idx] = 1'b0;
    chk("latency", 32'(w - 1), 32'(settle_of(idx)));

    for (int h = 0; h < hold; h++) begin
      if (intrude) begin
        in_valid[idx] = 1'b1;
        in_a[idx]     = 4'd2;
        in_b[idx]     = 4'd1;
      end
      step();
      chk("hold_valid", 32'(out_valid[idx]), 32'd1);
      chk("hold_quo", 32'(out_quo[idx]), 32'(eq));
      chk("hold_in_ready", 32'(in_ready[idx]), 32'd0);
    end
    if (intrude) chk("intrude_div_a", 32'(div_a[idx]), 32'(a));
    in_valid[idx] = 1'b0;

    chk("quo", 32'(out_quo[idx]), 32'(eq));
    chk("rem", 32'(out_rem[idx]), 32'(er));
    chk("dest", 32'(out_dest[idx]), 32'(d));
    chk("dbz", 32'(out_dbz[idx]), 32'(edbz));

    out_ready[idx] = 1'b1;
    step();
    out_ready[idx] = 1'b0;
    exp_cnt[idx] = (exp_cnt[idx] + 1) % 256;
    chk("op_count", 32'(op_count[idx]), 32'(exp_cnt[idx]));
    chk("post_valid", 32'(out_valid[idx]), 32'd0);
    chk("post_in_ready", 32'(in_ready[idx]), 32'd1);
    chk("persist_quo", 32'(out_quo[idx]), 32'(eq));
    chk("persist_rem", 32'(out_rem[idx]), 32'(er));
    chk("persist_div_a", 32'(div_a[idx]), 32'(a));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    junk     = 4'd0;
    for (int i = 0; i < 2; i++) begin
      rst_n[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      in_a[i]      = 4'd0;
      in_b[i]      = 4'd0;
      in_dest[i]   = 3'd0;
      out_ready[i] = 1'b0;
      exp_cnt[i]   = 0;
    end

    // Reset state
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 32'(in_ready[i]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_op_count", 32'(op_count[i]), 32'd0);
      chk("rst_div_a", 32'(div_a[i]), 32'd0);
      chk("rst_out_quo", 32'(out_quo[i]), 32'd0);
      rst_n[i] = 1'b1;
    end
    #1;
    chk("idle_ready0", 32'(in_ready[0]), 32'd1);
    chk("idle_ready1", 32'(in_ready[1]), 32'd1);

    // T1 basic op, T2 divide by zero, T3 long stall with ignored intruder
    do_op(0, 4'd13, 4'd4, 3'd5, 0, 1'b0);
    do_op(0, 4'd9, 4'd0, 3'd1, 1, 1'b0);
    do_op(0, 4'd7, 4'd3, 3'd6, 5, 1'b1);

    // T4 reset during SETTLE on the 3-cycle instance
    do_op(1, 4'd11, 4'd3, 3'd4, 2, 1'b0);
    in_valid[1] = 1'b1;
    in_a[1]     = 4'd5;
    in_b[1]     = 4'd3;
    in_dest[1]  = 3'd2;
    step();
    in_valid[1] = 1'b0;
    step();
    rst_n[1] = 1'b0;
    #1;
    chk("t4_ready_in_rst", 32'(in_ready[1]), 32'd0);
    step();
    rst_n[1] = 1'b1;
    #1;
    exp_cnt[1] = 0;
    chk("t4_out_valid", 32'(out_valid[1]), 32'd0);
    chk("t4_div_a", 32'(div_a[1]), 32'd0);
    chk("t4_div_b", 32'(div_b[1]), 32'd0);
    chk("t4_out_quo", 32'(out_quo[1]), 32'd0);
    chk("t4_out_rem", 32'(out_rem[1]), 32'd0);
    chk("t4_out_dest", 32'(out_dest[1]), 32'd0);
    chk("t4_op_count", 32'(op_count[1]), 32'd0);
    chk("t4_in_ready", 32'(in_ready[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_no_result", 32'(out_valid[1]), 32'd0);
    end
    do_op(1, 4'd15, 4'd2, 3'd3, 1, 1'b0);

    // T5 every (a,b) pair with random writeback stalls
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(0, 4'(a), 4'(b), 3'($urandom), int'($urandom_range(0, 3)), 1'b0);
      end
    end

    // T6 run the counter up to 255, then one more op must wrap it to 0
    while (exp_cnt[0] != 255) begin
      do_op(0, 4'($urandom), 4'($urandom), 3'($urandom), 0, 1'b0);
    end
    chk("at_255", 32'(op_count[0]), 32'd255);
    do_op(0, 4'd14, 4'd5, 3'd7, 0, 1'b0);
    chk("wrap_zero", 32'(op_count[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
